// File: rtl/cmp_pkg.sv
// Shared encodings and helpers for the chunked comparator.
// Covers branch funct3 decode, ALU funct3 decode and the FSM state type.
package cmp_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;

  localparam logic [2:0] F3_MIN  = 3'b100;
  localparam logic [2:0] F3_MINU = 3'b101;
  localparam logic [2:0] F3_MAX  = 3'b110;
  localparam logic [2:0] F3_MAXU = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic f_is_signed(input logic is_branch, input logic minmax,
                                       input logic [2:0] func3);
    if (is_branch)   return (func3 == F3_BLT) || (func3 == F3_BGE);
    else if (minmax) return (func3 == F3_MIN) || (func3 == F3_MAX);
    else             return (func3 == F3_SLT);
  endfunction

  function automatic logic f_branch_taken(input logic [2:0] func3, input logic lt,
                                          input logic eq);
    case (func3)
      F3_BEQ:  return eq;
      F3_BNE:  return !eq;
      F3_BLT:  return lt;
      F3_BGE:  return !lt;
      F3_BLTU: return lt;
      F3_BGEU: return !lt;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned less-than / equal of one CHUNK-bit operand slice.
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  output logic             o_lt,
  output logic             o_eq
);

  assign o_lt = (i_a < i_b);
  assign o_eq = (i_a == i_b);

endmodule

// File: rtl/chunked_compare_unit.sv
// Multi-cycle MSB-first chunked comparator for SLT/SLTU and RV32 branch conditions.
// Optional Zbb MIN/MINU/MAX/MAXU selection is built when CMP_MINMAX_EN is defined.
//
// state | meaning
// IDLE  | ready to accept an operation
// BUSY  | comparing one chunk per cycle, MSB chunk first
// DONE  | result held until the consumer takes it
module chunked_compare_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_is_branch,
  input  logic [2:0]       i_func3,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
`ifdef CMP_MINMAX_EN
  input  logic             i_minmax,
`endif
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out,
  output logic             o_taken
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("chunked_compare_unit: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_t            r_state;
  state_t            w_next_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [2:0]        r_func3;
  logic              r_is_branch;
  logic              r_minmax;
  logic              r_signed;
  logic [IDXW-1:0]   r_idx;
  logic [WIDTH-1:0]  r_out;
  logic              r_taken;

  logic              w_minmax;
  logic [WIDTH-1:0]  w_flip;
  logic [WIDTH-1:0]  w_a_cmp;
  logic [WIDTH-1:0]  w_b_cmp;
  logic [CHUNK-1:0]  w_a_chunk;
  logic [CHUNK-1:0]  w_b_chunk;
  logic              w_chunk_lt;
  logic              w_chunk_eq;
  logic              w_finish;
  logic              w_lt_final;
  logic [WIDTH-1:0]  w_res_out;
  logic              w_res_taken;

`ifdef CMP_MINMAX_EN
  assign w_minmax = i_minmax;
`else
  assign w_minmax = 1'b0;
`endif

  // Signed order maps onto unsigned order once the sign bits are inverted.
  assign w_flip    = r_signed ? MSB_MASK : '0;
  assign w_a_cmp   = r_a ^ w_flip;
  assign w_b_cmp   = r_b ^ w_flip;
  assign w_a_chunk = w_a_cmp[r_idx*CHUNK +: CHUNK];
  assign w_b_chunk = w_b_cmp[r_idx*CHUNK +: CHUNK];

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .i_a  (w_a_chunk),
    .i_b  (w_b_chunk),
    .o_lt (w_chunk_lt),
    .o_eq (w_chunk_eq)
  );

  assign w_finish   = (r_state == BUSY) && (!w_chunk_eq || (r_idx == '0));
  assign w_lt_final = !w_chunk_eq && w_chunk_lt;

  always_comb begin
    w_res_out   = '0;
    w_res_taken = 1'b0;
    if (r_is_branch) begin
      w_res_taken = f_branch_taken(r_func3, w_lt_final, w_chunk_eq);
    end else if (r_minmax && r_func3[2]) begin
      // func3[1] separates MAX from MIN: MAX picks operand A when A is not below B.
      w_res_out = (w_lt_final ^ r_func3[1]) ? r_a : r_b;
    end else if ((r_func3 == F3_SLT) || (r_func3 == F3_SLTU)) begin
      w_res_out = {{(WIDTH-1){1'b0}}, w_lt_final};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_in_valid)  w_next_state = BUSY;
      BUSY:    if (w_finish)    w_next_state = DONE;
      DONE:    if (i_out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    o_in_ready  = (r_state == IDLE);
    o_out_valid = (r_state == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_func3     <= '0;
      r_is_branch <= 1'b0;
      r_minmax    <= 1'b0;
      r_signed    <= 1'b0;
      r_idx       <= '0;
      r_out       <= '0;
      r_taken     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_a         <= i_rs1_data;
            r_b         <= i_rs2_data;
            r_func3     <= i_func3;
            r_is_branch <= i_is_branch;
            r_minmax    <= w_minmax;
            r_signed    <= f_is_signed(i_is_branch, w_minmax, i_func3);
            r_idx       <= IDXW'(N-1);
          end
        end
        BUSY: begin
          if (w_finish) begin
            r_out   <= w_res_out;
            r_taken <= w_res_taken;
          end else begin
            r_idx <= r_idx - IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_out   = r_out;
  assign o_taken = r_taken;

endmodule
